// File: rtl/mc8051_instr_seq.sv
// Instruction sequencer for the mc8051 core: fetches opcodes, steps ci_stage, owns the PC.
// Optional interrupt pseudo-opcode injection at instruction boundaries: MC8051_INT_INJECT_EN.
module mc8051_instr_seq #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [7:0]          INT_OPCODE   = 8'hA5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_mem_req,
  output logic [PC_WIDTH-1:0] o_pc,
  input  logic [7:0]          i_mem_rdata,
  input  logic                i_mem_rvalid,
  input  logic                i_mc_last,
  input  logic                i_stall,
  input  logic                i_pc_inc,
  input  logic                i_pc_load,
  input  logic [PC_WIDTH-1:0] i_pc_load_val,
  input  logic                i_int_req,
  output logic [7:0]          o_instr_buffer,
  output logic [1:0]          o_ci_stage,
  output logic                o_instr_valid,
  output logic                o_seq_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          buf_q, buf_d;
  logic [1:0]          stage_q, stage_d;
  logic                inj_q, inj_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      buf_q   <= 8'h00;
      stage_q <= 2'b00;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      stage_q <= stage_d;
      inj_q   <= inj_d;
    end
  end

  // An overrun at stage 3 ends the instruction exactly like i_mc_last, but flags o_seq_err.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    stage_d   = stage_q;
    inj_d     = inj_q;
    o_seq_err = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (i_mem_rvalid) begin
          buf_d   = i_mem_rdata;
          pc_d    = pc_q + PC_WIDTH'(1);
          stage_d = 2'b00;
          inj_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!i_stall) begin
          if (i_pc_load) begin
            pc_d = i_pc_load_val;
          end else if (i_pc_inc) begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
          if (i_mc_last || (stage_q == 2'd3)) begin
            o_seq_err = !i_mc_last;
            state_d   = FETCH;
`ifdef MC8051_INT_INJECT_EN
            // inj_q blocks a second injection right after an injected instruction.
            if (i_int_req && !inj_q) begin
              state_d = EXEC;
              buf_d   = INT_OPCODE;
              stage_d = 2'b00;
              inj_d   = 1'b1;
            end
`endif
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef MC8051_INT_INJECT_EN
  logic unused_int;
  assign unused_int = ^{i_int_req, INT_OPCODE, inj_q};
`endif

  assign o_mem_req      = (state_q == FETCH);
  assign o_instr_valid  = (state_q == EXEC);
  assign o_pc           = pc_q;
  assign o_instr_buffer = buf_q;
  assign o_ci_stage     = stage_q;

endmodule

// File: tb/tb_mc8051_instr_seq.sv
// Directed self-checking bench for mc8051_instr_seq with a simple one-cycle-latency code memory.
module tb_mc8051_instr_seq;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        memReq;
  logic [15:0] pc;
  logic [7:0]  memRdata = 8'h00;
  logic        memRvalid = 1'b0;
  logic        mcLast = 1'b0;
  logic        stall = 1'b0;
  logic        pcInc = 1'b0;
  logic        pcLoad = 1'b0;
  logic [15:0] pcLoadVal = 16'h0000;
  logic        intReq = 1'b0;
  logic [7:0]  instrBuffer;
  logic [1:0]  ciStage;
  logic        instrValid;
  logic        seqErr;

  logic [7:0]  memByte = 8'h00;
  logic        forceRv = 1'b0;
  logic        reqPrev = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc;
  bit          reqOk;

  mc8051_instr_seq dut (
    .i_clk(clock), .i_rst_n(resetN), .o_mem_req(memReq), .o_pc(pc),
    .i_mem_rdata(memRdata), .i_mem_rvalid(memRvalid), .i_mc_last(mcLast),
    .i_stall(stall), .i_pc_inc(pcInc), .i_pc_load(pcLoad), .i_pc_load_val(pcLoadVal),
    .i_int_req(intReq), .o_instr_buffer(instrBuffer), .o_ci_stage(ciStage),
    .o_instr_valid(instrValid), .o_seq_err(seqErr)
  );

  always #5 clock = ~clock;

  // Memory answers in the cycle after the one where it first saw a request.
  always @(negedge clock) begin
    memRvalid = (memReq && reqPrev) || forceRv;
    memRdata  = memByte;
    reqPrev   = memReq;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic runToExec(output int cycles, output bit reqHigh);
    cycles = 0;
    reqHigh = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #1;
      if (instrValid === 1'b1) break;
      cycles++;
      if (memReq !== 1'b1) reqHigh = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    #1;
    compared++; if (pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 16'h0000); end
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req: got %b want 0", memReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", instrValid); end
    compared++; if (instrBuffer !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_buf: got %h want 00", instrBuffer); end
    compared++; if (ciStage !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_stage: got %0d want 0", ciStage); end
    compared++; if (seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", seqErr); end
    @(negedge clock);
    resetN = 1'b1;
    #1;
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_req: got %b want 0", memReq); end
  endtask

  task automatic test_basic;
    memByte = 8'h00;
    mcLast = 1'b1;
    runToExec(cyc, reqOk);
    compared++; if (cyc != 2 || !reqOk) begin mismatched++; $display("[TB] FAIL basic_fetch1: got %0d cycles req_ok=%0b want 2 cycles req_ok=1", cyc, reqOk); end
    compared++; if (pc !== 16'h0001) begin mismatched++; $display("[TB] FAIL basic_pc1: got %h want 0001", pc); end
    compared++; if (ciStage !== 2'd0 || instrBuffer !== 8'h00) begin mismatched++; $display("[TB] FAIL basic_exec1: got stage %0d buf %h want 0 00", ciStage, instrBuffer); end
    runToExec(cyc, reqOk);
    compared++; if (cyc != 2 || !reqOk) begin mismatched++; $display("[TB] FAIL basic_fetch2: got %0d cycles req_ok=%0b want 2 cycles req_ok=1", cyc, reqOk); end
    compared++; if (pc !== 16'h0002) begin mismatched++; $display("[TB] FAIL basic_pc2: got %h want 0002", pc); end
  endtask

  task automatic test_multi_stage;
    memByte = 8'h74;
    runToExec(cyc, reqOk);
    mcLast = 1'b0;
    compared++; if (instrBuffer !== 8'h74 || pc !== 16'h0003 || ciStage !== 2'd0) begin mismatched++; $display("[TB] FAIL mov_s0: got buf %h pc %h stage %0d want 74 0003 0", instrBuffer, pc, ciStage); end
    @(negedge clock); #1;
    compared++; if (ciStage !== 2'd1 || pc !== 16'h0003) begin mismatched++; $display("[TB] FAIL mov_s1: got stage %0d pc %h want 1 0003", ciStage, pc); end
    pcInc = 1'b1;
    @(negedge clock); #1;
    compared++; if (ciStage !== 2'd2 || pc !== 16'h0004) begin mismatched++; $display("[TB] FAIL mov_s2: got stage %0d pc %h want 2 0004", ciStage, pc); end
    pcInc = 1'b0;
    mcLast = 1'b1;
    @(negedge clock); #1;
    compared++; if (memReq !== 1'b1 || instrValid !== 1'b0 || pc !== 16'h0004) begin mismatched++; $display("[TB] FAIL mov_refetch: got req %b valid %b pc %h want 1 0 0004", memReq, instrValid, pc); end
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0005 || cyc != 1) begin mismatched++; $display("[TB] FAIL mov_next: got pc %h cycles %0d want 0005 1", pc, cyc); end
  endtask

  task automatic test_stall;
    mcLast = 1'b0;
    @(negedge clock); #1;
    stall = 1'b1;
    pcInc = 1'b1;
    pcLoad = 1'b1;
    pcLoadVal = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      compared++; if (ciStage !== 2'd1 || instrBuffer !== 8'h74 || pc !== 16'h0005 || instrValid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL stall_hold%0d: got stage %0d buf %h pc %h valid %b want 1 74 0005 1", i, ciStage, instrBuffer, pc, instrValid);
      end
    end
    stall = 1'b0;
    pcInc = 1'b0;
    pcLoad = 1'b0;
    mcLast = 1'b1;
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0006 || cyc != 2) begin mismatched++; $display("[TB] FAIL stall_after: got pc %h cycles %0d want 0006 2", pc, cyc); end
  endtask

  task automatic test_overrun;
    memByte = 8'hE4;
    mcLast = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      compared++; if (seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_early_err%0d: got %b want 0", s, seqErr); end
      @(negedge clock); #1;
    end
    compared++; if (ciStage !== 2'd3 || seqErr !== 1'b1) begin mismatched++; $display("[TB] FAIL overrun_s3: got stage %0d err %b want 3 1", ciStage, seqErr); end
    @(negedge clock); #1;
    compared++; if (memReq !== 1'b1 || seqErr !== 1'b0 || instrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_fetch: got req %b err %b valid %b want 1 0 0", memReq, seqErr, instrValid); end
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0007 || instrBuffer !== 8'hE4) begin mismatched++; $display("[TB] FAIL overrun_next: got pc %h buf %h want 0007 e4", pc, instrBuffer); end
  endtask

  task automatic test_rvalid_ignored;
    mcLast = 1'b0;
    forceRv = 1'b1;
    memByte = 8'h33;
    @(negedge clock); #1;
    @(negedge clock); #1;
    compared++; if (ciStage !== 2'd2 || instrBuffer !== 8'hE4 || pc !== 16'h0007) begin mismatched++; $display("[TB] FAIL rvalid_exec: got stage %0d buf %h pc %h want 2 e4 0007", ciStage, instrBuffer, pc); end
    forceRv = 1'b0;
    mcLast = 1'b1;
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0008 || instrBuffer !== 8'h33 || cyc != 2) begin mismatched++; $display("[TB] FAIL rvalid_next: got pc %h buf %h cycles %0d want 0008 33 2", pc, instrBuffer, cyc); end
  endtask

  task automatic test_pc_load;
    pcLoad = 1'b1;
    pcInc = 1'b1;
    pcLoadVal = 16'h1234;
    mcLast = 1'b1;
    @(negedge clock); #1;
    compared++; if (memReq !== 1'b1 || pc !== 16'h1234) begin mismatched++; $display("[TB] FAIL load_req: got req %b pc %h want 1 1234", memReq, pc); end
    pcLoad = 1'b0;
    pcInc = 1'b0;
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h1235) begin mismatched++; $display("[TB] FAIL load_next: got pc %h want 1235", pc); end
    pcLoad = 1'b1;
    pcLoadVal = 16'hFFFF;
    @(negedge clock); #1;
    compared++; if (pc !== 16'hFFFF || memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_req: got pc %h req %b want ffff 1", pc, memReq); end
    pcLoadVal = 16'h5555;
    runToExec(cyc, reqOk);
    pcLoad = 1'b0;
    compared++; if (pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap_pc: got %h want 0000", pc); end
  endtask

  task automatic test_interrupt;
    intReq = 1'b1;
    mcLast = 1'b1;
    @(negedge clock); #1;
`ifdef MC8051_INT_INJECT_EN
    compared++; if (instrValid !== 1'b1 || memReq !== 1'b0 || instrBuffer !== 8'hA5 || ciStage !== 2'd0 || pc !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL int_inject: got valid %b req %b buf %h stage %0d pc %h want 1 0 a5 0 0000", instrValid, memReq, instrBuffer, ciStage, pc);
    end
    @(negedge clock); #1;
    compared++; if (memReq !== 1'b1 || instrValid !== 1'b0 || pc !== 16'h0000) begin mismatched++; $display("[TB] FAIL int_no_b2b: got req %b valid %b pc %h want 1 0 0000", memReq, instrValid, pc); end
`else
    compared++; if (memReq !== 1'b1 || instrValid !== 1'b0 || instrBuffer !== 8'h33 || pc !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL int_ignored: got req %b valid %b buf %h pc %h want 1 0 33 0000", memReq, instrValid, instrBuffer, pc);
    end
`endif
    intReq = 1'b0;
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0001 || instrBuffer !== 8'h33) begin mismatched++; $display("[TB] FAIL int_after: got pc %h buf %h want 0001 33", pc, instrBuffer); end
  endtask

  task automatic test_async_reset;
    mcLast = 1'b1;
    @(negedge clock); #1;
    @(negedge clock); #2;
    resetN = 1'b0;
    #1;
    compared++; if (pc !== 16'h0000 || memReq !== 1'b0 || instrValid !== 1'b0 || instrBuffer !== 8'h00 || ciStage !== 2'd0) begin
      mismatched++; $display("[TB] FAIL async_reset: got pc %h req %b valid %b buf %h stage %0d want 0000 0 0 00 0", pc, memReq, instrValid, instrBuffer, ciStage);
    end
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    runToExec(cyc, reqOk);
    compared++; if (pc !== 16'h0001 || cyc != 2 || !reqOk) begin mismatched++; $display("[TB] FAIL async_restart: got pc %h cycles %0d req_ok %0b want 0001 2 1", pc, cyc, reqOk); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_stage();
    test_stall();
    test_overrun();
    test_rvalid_ignored();
    test_pc_load();
    test_interrupt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
